// File: rtl/vtisa_bus_pkg.sv
// Shared types and constants for the external memory bus sequencer.
package vtisa_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DATA = 2'd3
  } bus_state_e;

  localparam logic REQ_IF     = 1'b0;
  localparam logic REQ_D      = 1'b1;

  localparam logic ADDR_PHASE = 1'b1;
  localparam logic SEL_ROM    = 1'b0;
  localparam logic SEL_RAM    = 1'b1;

  // Pad select for a given requester id.
  function automatic logic bus_sel(input logic req_id);
    return (req_id == REQ_D) ? SEL_RAM : SEL_ROM;
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin arbiter; bit REQ_IF is fetch, bit REQ_D is data.
module mem_rr_arb
  import vtisa_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       accept_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic       last_q;
  logic       last_d;
  logic [1:0] elig_s;

  // Grant selection and pointer next-state
  always_comb begin
    elig_s      = req_i & ~mask_i;
    gnt_valid_o = |elig_s;
    if (elig_s == 2'b11) begin
      gnt_id_o = ~last_q;
    end else if (elig_s[REQ_D]) begin
      gnt_id_o = REQ_D;
    end else begin
      gnt_id_o = REQ_IF;
    end
    if (accept_i && gnt_valid_o) begin
      last_d = gnt_id_o;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant pointer; starts at fetch so data wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_IF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// External 8-bit memory bus sequencer: address phase, optional wait states,
// data phase, with round-robin sharing between fetch and data requesters.
module mem_bus_ctrl
  import vtisa_bus_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [7:0]        if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_wdata,
  output logic              d_done,
  output logic [7:0]        d_rdata,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  output logic              bus_addr_data,
  output logic              bus_rom_ram,
  output logic              bus_we
);

  localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [7:0]        if_rdata_q, if_rdata_d;
  logic [7:0]        d_rdata_q, d_rdata_d;
  logic [7:0]        bus_out_q, bus_out_d;
  logic              bus_ad_q, bus_ad_d;
  logic              bus_rr_q, bus_rr_d;
  logic              bus_we_q, bus_we_d;

  logic              gnt_valid_s;
  logic              gnt_id_s;

  // A requester is masked while its done pulse is showing
  mem_rr_arb u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       ({d_req, if_req}),
    .mask_i      ({d_done_q, if_done_q}),
    .accept_i    (state_q == IDLE),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) state_d = ADDR;
        else             state_d = IDLE;
      end
      ADDR: begin
        if (HAS_WAIT) state_d = WAIT;
        else          state_d = DATA;
      end
      WAIT: begin
        if (wcnt_q == 4'd0) state_d = DATA;
        else                state_d = WAIT;
      end
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter, done pulses and read capture
  always_comb begin
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wcnt_d     = wcnt_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s && (gnt_id_s == REQ_D)) begin
          gnt_d   = REQ_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
        end else if (gnt_valid_s) begin
          gnt_d   = REQ_IF;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = 8'h00;
        end else begin
          gnt_d   = gnt_q;
        end
      end
      ADDR: wcnt_d = WAIT_LOAD;
      WAIT: begin
        if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
        else                wcnt_d = wcnt_q;
      end
      DATA: begin
        if (gnt_q == REQ_D) begin
          d_done_d = 1'b1;
          if (!we_q) d_rdata_d = bus_in;
          else       d_rdata_d = d_rdata_q;
        end else begin
          if_done_d  = 1'b1;
          if_rdata_d = bus_in;
        end
      end
      default: wcnt_d = wcnt_q;
    endcase
  end

  // Pad values for the upcoming state, so the pads come straight from flops
  always_comb begin
    bus_out_d = 8'h00;
    bus_ad_d  = ~ADDR_PHASE;
    bus_rr_d  = SEL_ROM;
    bus_we_d  = 1'b0;
    case (state_d)
      ADDR: begin
        bus_out_d = addr_d;
        bus_ad_d  = ADDR_PHASE;
        bus_rr_d  = bus_sel(gnt_d);
      end
      WAIT: begin
        bus_out_d = addr_d;
        bus_rr_d  = bus_sel(gnt_d);
      end
      DATA: begin
        bus_out_d = we_d ? wdata_d : 8'h00;
        bus_rr_d  = bus_sel(gnt_d);
        bus_we_d  = we_d;
      end
      IDLE:    bus_out_d = 8'h00;
      default: bus_out_d = 8'h00;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= REQ_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      wcnt_q     <= 4'd0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= 8'h00;
      d_rdata_q  <= 8'h00;
      bus_out_q  <= 8'h00;
      bus_ad_q   <= 1'b0;
      bus_rr_q   <= 1'b0;
      bus_we_q   <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wcnt_q     <= wcnt_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      bus_out_q  <= bus_out_d;
      bus_ad_q   <= bus_ad_d;
      bus_rr_q   <= bus_rr_d;
      bus_we_q   <= bus_we_d;
    end
  end

  assign if_done       = if_done_q;
  assign if_rdata      = if_rdata_q;
  assign d_done        = d_done_q;
  assign d_rdata       = d_rdata_q;
  assign bus_out       = bus_out_q;
  assign bus_addr_data = bus_ad_q;
  assign bus_rom_ram   = bus_rr_q;
  assign bus_we        = bus_we_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: lane 0 runs WAIT_CYCLES=0, lane 1 runs WAIT_CYCLES=2,
// each compared every cycle against a transaction-level model.
module tb_mem_bus_ctrl;

  typedef struct packed {
    logic       if_req;
    logic [7:0] if_addr;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic [7:0] bus_in;
  } drv_t;

  // k: 0 = bus free, 1 = address cycle, last = wc+2 = data cycle
  typedef struct {
    int         k;
    logic       gid;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic       last;
    logic       ifd;
    logic       dd;
    logic [7:0] ifr;
    logic [7:0] dr;
  } mdl_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n;
  drv_t       drv [2];
  logic [1:0] ifd_v;
  logic [1:0] dd_v;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.k = 0; m.gid = 1'b0; m.addr = 8'h00; m.we = 1'b0; m.wdata = 8'h00;
    m.last = 1'b0; m.ifd = 1'b0; m.dd = 1'b0; m.ifr = 8'h00; m.dr = 8'h00;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int wc, drv_t d);
    mdl_t n;
    logic e_if, e_d;
    n = m;
    n.ifd = 1'b0;
    n.dd  = 1'b0;
    if (m.k == 0) begin
      e_if = d.if_req && !m.ifd;
      e_d  = d.d_req && !m.dd;
      if (e_if || e_d) begin
        n.gid   = (e_if && e_d) ? ~m.last : e_d;
        n.last  = n.gid;
        n.k     = 1;
        n.addr  = n.gid ? d.d_addr : d.if_addr;
        n.we    = n.gid & d.d_we;
        n.wdata = d.d_wdata;
      end
    end else if (m.k == wc + 2) begin
      n.k = 0;
      if (!m.gid) begin
        n.ifd = 1'b1;
        n.ifr = d.bus_in;
      end else begin
        n.dd = 1'b1;
        if (!m.we) n.dr = d.bus_in;
      end
    end else begin
      n.k = m.k + 1;
    end
    return n;
  endfunction

  // {bus_out, bus_addr_data, bus_rom_ram, bus_we}
  function automatic logic [10:0] mdl_bus(mdl_t m, int wc);
    if (m.k == 0)      return 11'd0;
    if (m.k == 1)      return {m.addr, 1'b1, m.gid, 1'b0};
    if (m.k == wc + 2) return {(m.we ? m.wdata : 8'h00), 1'b0, m.gid, m.we};
    return {m.addr, 1'b0, m.gid, 1'b0};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WC = 2 * g;
    logic       if_done, d_done, bus_addr_data, bus_rom_ram, bus_we;
    logic [7:0] if_rdata, d_rdata, bus_out;
    mdl_t       m;

    mem_bus_ctrl #(.ADDR_W(8), .WAIT_CYCLES(WC)) dut (
      .clk           (clk),
      .rst_n         (rst_n[g]),
      .if_req        (drv[g].if_req),
      .if_addr       (drv[g].if_addr),
      .if_done       (if_done),
      .if_rdata      (if_rdata),
      .d_req         (drv[g].d_req),
      .d_we          (drv[g].d_we),
      .d_addr        (drv[g].d_addr),
      .d_wdata       (drv[g].d_wdata),
      .d_done        (d_done),
      .d_rdata       (d_rdata),
      .bus_in        (drv[g].bus_in),
      .bus_out       (bus_out),
      .bus_addr_data (bus_addr_data),
      .bus_rom_ram   (bus_rom_ram),
      .bus_we        (bus_we)
    );

    assign ifd_v[g] = if_done;
    assign dd_v[g]  = d_done;

    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) m <= mdl_reset();
      else           m <= mdl_step(m, WC, drv[g]);
    end

    always @(negedge clk) begin
      check($sformatf("L%0d bus", g),
            32'({bus_out, bus_addr_data, bus_rom_ram, bus_we}), 32'(mdl_bus(m, WC)));
      check($sformatf("L%0d rsp", g),
            32'({if_done, d_done, if_rdata, d_rdata}), 32'({m.ifd, m.dd, m.ifr, m.dr}));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch0(input logic [7:0] a, input logic [7:0] dat);
    drv[0].if_req  = 1'b1;
    drv[0].if_addr = a;
    drv[0].bus_in  = dat;
    tick();
    check("fetch addr", 32'({lane[0].bus_out, lane[0].bus_addr_data, lane[0].bus_rom_ram}),
          32'({a, 1'b1, 1'b0}));
    tick();
    check("fetch data", 32'({lane[0].bus_out, lane[0].bus_addr_data, lane[0].bus_we}), 32'(0));
    tick();
    check("fetch done", 32'({lane[0].if_done, lane[0].d_done, lane[0].if_rdata}),
          32'({1'b1, 1'b0, dat}));
    drv[0].if_req = 1'b0;
  endtask

  task automatic agent_step(input int l);
    drv[l].bus_in = 8'($urandom);
    if (drv[l].if_req) begin
      if (ifd_v[l]) begin
        if ($urandom_range(0, 1) == 1) drv[l].if_req = 1'b0;
        else                           drv[l].if_addr = 8'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        drv[l].if_addr = 8'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      drv[l].if_req  = 1'b1;
      drv[l].if_addr = 8'($urandom);
    end
    if (drv[l].d_req) begin
      if (dd_v[l] && ($urandom_range(0, 1) == 1)) begin
        drv[l].d_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        drv[l].d_addr  = 8'($urandom);
        drv[l].d_wdata = 8'($urandom);
        drv[l].d_we    = 1'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      drv[l].d_req   = 1'b1;
      drv[l].d_addr  = 8'($urandom);
      drv[l].d_wdata = 8'($urandom);
      drv[l].d_we    = 1'($urandom);
    end
  endtask

  initial begin
    rst_n  = 2'b11;
    drv[0] = '0;
    drv[1] = '0;
    #1 rst_n = 2'b00;
    tick();
    check("reset outs", 32'({lane[0].bus_out, lane[0].bus_addr_data, lane[0].bus_rom_ram,
          lane[0].bus_we, lane[0].if_done, lane[0].d_done}), 32'(0));
    tick();
    #2 rst_n = 2'b11;
    tick();
    check("post reset", 32'({lane[0].if_rdata, lane[0].d_rdata, lane[0].bus_addr_data}), 32'(0));

    // Single fetch, then back-to-back fetches
    fetch0(8'h12, 8'hA5);
    tick();
    check("b2b no regrant", 32'({lane[0].bus_addr_data, lane[0].if_done}), 32'(0));
    fetch0(8'h13, 8'h5A);
    drv[0].if_req  = 1'b1;
    drv[0].if_addr = 8'h55;
    drv[0].bus_in  = 8'h66;
    tick();
    check("done mask", 32'({lane[0].bus_addr_data, lane[0].if_done}), 32'(0));
    tick();
    check("masked addr", 32'({lane[0].bus_out, lane[0].bus_addr_data}), 32'({8'h55, 1'b1}));
    tick();
    tick();
    check("masked done", 32'({lane[0].if_done, lane[0].if_rdata}), 32'({1'b1, 8'h66}));
    drv[0].if_req = 1'b0;

    // Store
    drv[0].d_req = 1'b1; drv[0].d_we = 1'b1;
    drv[0].d_addr = 8'h40; drv[0].d_wdata = 8'h3C;
    tick();
    check("st addr", 32'({lane[0].bus_out, lane[0].bus_addr_data, lane[0].bus_rom_ram,
          lane[0].bus_we}), 32'({8'h40, 1'b1, 1'b1, 1'b0}));
    tick();
    check("st data", 32'({lane[0].bus_out, lane[0].bus_addr_data, lane[0].bus_rom_ram,
          lane[0].bus_we}), 32'({8'h3C, 1'b0, 1'b1, 1'b1}));
    tick();
    check("st done", 32'({lane[0].d_done, lane[0].bus_we, lane[0].d_rdata}),
          32'({1'b1, 1'b0, 8'h00}));
    drv[0].d_req = 1'b0; drv[0].d_we = 1'b0;

    // Contention from reset: D, IF, D, IF
    #2 rst_n[0] = 1'b0;
    drv[0].if_req = 1'b1; drv[0].if_addr = 8'h20;
    drv[0].d_req  = 1'b1; drv[0].d_addr  = 8'h30; drv[0].bus_in = 8'h77;
    tick();
    tick();
    #2 rst_n[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr grant", 32'({lane[0].bus_addr_data, lane[0].bus_rom_ram, lane[0].bus_out}),
            32'({1'b1, (i % 2 == 0), ((i % 2 == 0) ? 8'h30 : 8'h20)}));
      tick();
      tick();
      check("rr done", 32'({lane[0].if_done, lane[0].d_done}),
            32'((i % 2 == 0) ? 2'b01 : 2'b10));
    end
    drv[0].if_req = 1'b0;
    drv[0].d_req  = 1'b0;

    // Reset during the data phase of a store
    tick();
    drv[0].d_req = 1'b1; drv[0].d_we = 1'b1;
    drv[0].d_addr = 8'h81; drv[0].d_wdata = 8'hE7;
    tick();
    tick();
    check("rst st data", 32'({lane[0].bus_out, lane[0].bus_we}), 32'({8'hE7, 1'b1}));
    #2 rst_n[0] = 1'b0;
    drv[0].d_req = 1'b0; drv[0].d_we = 1'b0;
    #1 check("async drop", 32'({lane[0].bus_we, lane[0].bus_out, lane[0].bus_addr_data,
             lane[0].bus_rom_ram}), 32'(0));
    tick();
    check("rst no done", 32'({lane[0].d_done, lane[0].d_rdata, lane[0].if_rdata}), 32'(0));
    #2 rst_n[0] = 1'b1;
    tick();
    check("rst released", 32'({lane[0].bus_out, lane[0].bus_we, lane[0].d_done}), 32'(0));
    fetch0(8'h5C, 8'hC3);

    // Two wait states, load on lane 1
    drv[1].d_req = 1'b1; drv[1].d_we = 1'b0;
    drv[1].d_addr = 8'h07; drv[1].bus_in = 8'h99;
    tick();
    check("w2 addr", 32'({lane[1].bus_out, lane[1].bus_addr_data, lane[1].bus_rom_ram}),
          32'({8'h07, 1'b1, 1'b1}));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("w2 wait", 32'({lane[1].bus_out, lane[1].bus_addr_data, lane[1].bus_rom_ram,
            lane[1].bus_we}), 32'({8'h07, 1'b0, 1'b1, 1'b0}));
    end
    tick();
    check("w2 data", 32'({lane[1].bus_out, lane[1].bus_addr_data, lane[1].bus_we,
          lane[1].d_done}), 32'(0));
    tick();
    check("w2 done", 32'({lane[1].d_done, lane[1].d_rdata}), 32'({1'b1, 8'h99}));
    drv[1].d_req = 1'b0;

    // Random traffic on both lanes
    for (int c = 0; c < 3000; c++) begin
      tick();
      agent_step(0);
      agent_step(1);
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
